// File: rtl/video_scanout_controller.sv
// video_scanout_controller: VGA raster timing generator with a raster-order
// framebuffer prefetcher and a first-word-fall-through pixel FIFO.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   pixel_tick            pixel-rate enable; raster advances only when high
//   frame_select          requested frame, latched at each frame boundary
//   fb_req/fb_addr/       framebuffer read request; address and frame are
//   fb_frame              held stable while fb_req waits for fb_ack
//   fb_ack/fb_data        request accepted, read byte valid this cycle
//   pixel_x_pos/_y_pos    current raster counters
//   pixel_data            FIFO head while active and non-empty, else 0
//   active_video, hsync,  registered raster qualifiers, aligned with the
//   vsync                 counters (syncs are active-low)
//   underflow             sticky FIFO underrun, cleared by underflow_clear

module video_scanout_controller #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        frame_select,
    output logic        fb_req,
    output logic [18:0] fb_addr,
    output logic        fb_frame,
    input  logic        fb_ack,
    input  logic [7:0]  fb_data,
    output logic [9:0]  pixel_x_pos,
    output logic [9:0]  pixel_y_pos,
    output logic [7:0]  pixel_data,
    output logic        active_video,
    output logic        hsync,
    output logic        vsync,
    output logic        underflow,
    input  logic        underflow_clear
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT_L  = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_FLUSH  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] FRAME_END = 19'(H_ACTIVE * V_ACTIVE);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // FETCH_DROP: request issued for the previous frame is still waiting
    // for its ack; that byte is thrown away when it arrives.
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DROP
    } fetch_state_t;

    fetch_state_t state_q, state_d;

    logic [9:0]    h_q, v_q, h_d, v_d;
    logic          hsync_q, vsync_q, active_q;
    logic          last_h, last_v, flush;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty, push, pop, uf_set;

    logic [18:0]   fetch_addr, fetch_d;
    logic          frame_q, frame_d;
    logic [18:0]   fb_addr_q;
    logic          fb_frame_q;
    logic          hold_req;
    logic          underflow_q;

    // Raster counters

    assign last_h = (h_q == H_LAST);
    assign last_v = (v_q == V_LAST);

    // The tick that moves the raster onto (0, V_ACTIVE) starts the next
    // frame's prefetch: all of vertical blanking is available to refill.
    assign flush = pixel_tick && last_h && (v_q == V_FLUSH);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pixel_tick) begin
            if (last_h) begin
                h_d = '0;
                v_d = last_v ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Qualifiers are computed from the next counter values so they land
    // in the same cycle as the counters they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b1;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= !((h_d >= HS_START) && (h_d < HS_END));
            vsync_q  <= !((v_d >= VS_START) && (v_d < VS_END));
            active_q <= (h_d < H_ACT_L) && (v_d < V_ACT_L);
        end
    end

    // Fetch FSM

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (!flush && (fetch_addr < FRAME_END) &&
                    (count < DEPTH_C)) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (fb_ack) begin
                    state_d = FETCH_IDLE;
                end else if (flush) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (fb_ack) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // An ack landing on the flush cycle belongs to the old frame, so it
    // is dropped exactly like one arriving in FETCH_DROP.
    assign push     = (state_q == FETCH_REQ) && fb_ack && !flush;
    assign hold_req = (state_q != FETCH_IDLE) && !fb_ack;

    assign fetch_d = flush ? '0 :
                     push  ? fetch_addr + 19'd1 : fetch_addr;
    assign frame_d = flush ? frame_select : frame_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_addr <= '0;
            frame_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_frame_q <= 1'b0;
        end else begin
            fetch_addr <= fetch_d;
            frame_q    <= frame_d;
            if (!hold_req) begin
                fb_addr_q  <= fetch_d;
                fb_frame_q <= frame_d;
            end
        end
    end

    // Prefetch FIFO

    assign fifo_empty = (count == '0);
    assign pop        = pixel_tick && active_q && !fifo_empty;
    assign uf_set     = pixel_tick && active_q && fifo_empty;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= fb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Underrun status: a set in the same cycle as a clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else if (uf_set) begin
            underflow_q <= 1'b1;
        end else if (underflow_clear) begin
            underflow_q <= 1'b0;
        end
    end

    // Outputs

    assign fb_req       = (state_q != FETCH_IDLE);
    assign fb_addr      = fb_addr_q;
    assign fb_frame     = fb_frame_q;
    assign pixel_x_pos  = h_q;
    assign pixel_y_pos  = v_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign active_video = active_q;
    assign underflow    = underflow_q;
    assign pixel_data   = (active_q && !fifo_empty) ?
                          fifo_mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_video_scanout_controller.sv
// Bench for video_scanout_controller on a reduced raster (24x14 total,
// 16x8 active) so several whole frames fit in a short run.

module tb_video_scanout_controller;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 8, VFP = 2, VSW = 2, VBP = 2;
    localparam int DEPTH = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int T_FL = VA * HT - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_tick = 1'b0;
    logic        frame_select = 1'b0;
    logic        fb_req;
    logic [18:0] fb_addr;
    logic        fb_frame;
    logic        fb_ack = 1'b0;
    logic [7:0]  fb_data = 8'h00;
    logic [9:0]  pixel_x_pos, pixel_y_pos;
    logic [7:0]  pixel_data;
    logic        active_video, hsync, vsync, underflow;
    logic        underflow_clear = 1'b0;

    video_scanout_controller #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .pixel_tick(pixel_tick),
        .frame_select(frame_select), .fb_req(fb_req), .fb_addr(fb_addr),
        .fb_frame(fb_frame), .fb_ack(fb_ack), .fb_data(fb_data),
        .pixel_x_pos(pixel_x_pos), .pixel_y_pos(pixel_y_pos),
        .pixel_data(pixel_data), .active_video(active_video),
        .hsync(hsync), .vsync(vsync), .underflow(underflow),
        .underflow_clear(underflow_clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        int t;
        int h;
        int v;
        bit hs;
        bit vs;
        bit act;
    } tvec_t;

    tvec_t tv [15];

    int   n_checks = 0;
    int   n_err = 0;
    int   t = 0;
    int   kclk = 0;
    logic cur_frame = 1'b0;
    bit   chk_pix = 0;
    bit   mem_en = 0;
    bit   rand_lat = 0;
    int   fix_lat = 1;
    int   cur_lat = 0;
    int   wait_cnt = 0;
    logic [19:0] ack_q [$];

    function automatic logic [7:0] memfn(input logic [18:0] a, input logic f);
        return a[7:0] ^ (f ? 8'h5A : 8'h00);
    endfunction

    function automatic logic [22:0] exp_timing(input int tt);
        int h, v;
        logic hs, vs, act;
        h = tt % HT;
        v = (tt / HT) % VT;
        hs = !(h >= HA + HFP && h < HA + HFP + HSW);
        vs = !(v >= VA + VFP && v < VA + VFP + VSW);
        act = (h < HA) && (v < VA);
        return {10'(h), 10'(v), hs, vs, act};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
        end
    endtask

    // Framebuffer: fixed or random ack latency, data derived from address
    // and frame, every accepted request logged as {frame, addr}.
    always @(negedge clock) begin
        if (reset || !mem_en || !fb_req) begin
            fb_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0)
                cur_lat = rand_lat ? int'($urandom_range(0, 2)) : fix_lat;
            if (wait_cnt >= cur_lat) begin
                fb_ack = 1'b1;
                fb_data = memfn(fb_addr, fb_frame);
                ack_q.push_back({fb_frame, fb_addr});
                wait_cnt = 0;
            end else begin
                fb_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // One clock. Before the edge: check the pixel about to be consumed.
    // After it: check raster outputs against the tick count.
    task automatic step(input logic tk);
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        if (tk && chk_pix && h < HA && v < VA) begin
            chk("pixel", pixel_data, memfn(19'(v * HA + h), cur_frame));
            chk("no_underflow", underflow, 0);
        end
        pixel_tick = tk;
        if (tk) begin
            if (h == HT - 1 && v == VA - 1) cur_frame = frame_select;
            t++;
        end
        kclk++;
        @(negedge clock);
        chk("timing", {pixel_x_pos, pixel_y_pos, hsync, vsync, active_video},
            exp_timing(t));
    endtask

    task automatic run_p4_until(input int tt);
        while (t < tt) step((kclk % 4) == 3);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        pixel_tick = 1'b0;
        underflow_clear = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        t = 0;
        kclk = 0;
        cur_frame = 1'b0;
        ack_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{0,   0,  0,  1, 1, 1};
        tv[1]  = '{15,  15, 0,  1, 1, 1};
        tv[2]  = '{16,  16, 0,  1, 1, 0};
        tv[3]  = '{17,  17, 0,  1, 1, 0};
        tv[4]  = '{18,  18, 0,  0, 1, 0};
        tv[5]  = '{20,  20, 0,  0, 1, 0};
        tv[6]  = '{21,  21, 0,  1, 1, 0};
        tv[7]  = '{23,  23, 0,  1, 1, 0};
        tv[8]  = '{24,  0,  1,  1, 1, 1};
        tv[9]  = '{192, 0,  8,  1, 1, 0};
        tv[10] = '{240, 0,  10, 1, 0, 0};
        tv[11] = '{283, 19, 11, 0, 0, 0};
        tv[12] = '{288, 0,  12, 1, 1, 0};
        tv[13] = '{335, 23, 13, 1, 1, 0};
        tv[14] = '{336, 0,  0,  1, 1, 1};

        // Reset state, then raster timing with pixel_tick held high
        do_reset;
        chk("rst_x", pixel_x_pos, 0);
        chk("rst_y", pixel_y_pos, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_fb_req", fb_req, 0);
        chk("rst_fb_frame", fb_frame, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_pixel", pixel_data, 0);
        for (int i = 0; i < 15; i++) begin
            while (t < tv[i].t) step(1);
            chk($sformatf("tvec%0d", i),
                {pixel_x_pos, pixel_y_pos, hsync, vsync, active_video},
                {10'(tv[i].h), 10'(tv[i].v), tv[i].hs, tv[i].vs, tv[i].act});
        end

        // Streaming at one pixel per 4 clocks, ack latency 1, and a frame
        // switch requested mid-frame
        do_reset;
        mem_en = 1; rand_lat = 0; fix_lat = 1;
        frame_select = 1'b0;
        chk_pix = 1;
        repeat (4) step(0);
        run_p4_until(2 * HT);
        frame_select = 1'b1;
        run_p4_until(T_FL);
        chk("frame_hold", fb_frame, 0);
        ack_q.delete();
        run_p4_until(T_FL + 1);
        chk("frame_switch", fb_frame, 1);
        for (int i = 0; i < 40 && ack_q.size() == 0; i++)
            step((kclk % 4) == 3);
        if (ack_q.size() == 0) chk("first_ack_timeout", 0, 1);
        else chk("first_ack", ack_q[0], {1'b1, 19'd0});
        run_p4_until(FT + 2 * HT);
        chk("stream_underflow", underflow, 0);

        // Backpressure: no pixel ticks, immediate acks
        do_reset;
        chk_pix = 0;
        fix_lat = 0;
        repeat (30) step(0);
        chk("bp_acks", ack_q.size(), DEPTH);
        chk("bp_req", fb_req, 0);
        repeat (10) begin
            step(0);
            chk("bp_req_hold", fb_req, 0);
        end

        // Framebuffer never acks
        do_reset;
        mem_en = 0;
        repeat (3) step(0);
        chk("na_req", fb_req, 1);
        chk("na_uf0", underflow, 0);
        chk("na_pix", pixel_data, 0);
        step(1);
        chk("na_uf_set", underflow, 1);
        underflow_clear = 1'b1;
        step(0);
        underflow_clear = 1'b0;
        chk("na_uf_clr", underflow, 0);
        repeat (3) step(0);
        chk("na_uf_stay", underflow, 0);
        underflow_clear = 1'b1;
        step(1);
        underflow_clear = 1'b0;
        chk("na_uf_setwins", underflow, 1);

        // Request held unacked across the frame boundary
        do_reset;
        mem_en = 1; fix_lat = 0;
        frame_select = 1'b1;
        chk_pix = 1;
        repeat (4) step(0);
        run_p4_until((VA - 1) * HT);
        mem_en = 0;
        chk_pix = 0;
        run_p4_until(T_FL + 1);
        repeat (3) step((kclk % 4) == 3);
        chk("drop_req_held", fb_req, 1);
        chk("drop_frame_held", fb_frame, 0);
        ack_q.delete();
        mem_en = 1;
        for (int i = 0; i < 20 && ack_q.size() < 2; i++)
            step((kclk % 4) == 3);
        if (ack_q.size() < 2) begin
            chk("drop_ack_timeout", 0, 1);
        end else begin
            chk("drop_old_frame", ack_q[0][19], 0);
            chk("restart_addr", ack_q[1], {1'b1, 19'd0});
        end
        run_p4_until(FT);
        chk("first_pixel_new", pixel_data, memfn(19'd0, 1'b1));
        underflow_clear = 1'b1;
        step(0);
        underflow_clear = 1'b0;
        chk_pix = 1;
        run_p4_until(FT + 2 * HT);
        chk("drop_underflow", underflow, 0);

        // Random tick spacing, random ack latency, random frame switches
        do_reset;
        mem_en = 1; rand_lat = 1;
        frame_select = 1'b0;
        chk_pix = 1;
        repeat (6) step(0);
        while (t < 3 * FT) begin
            if ($urandom_range(0, 39) == 0) frame_select = ~frame_select;
            repeat ($urandom_range(4, 6)) step(0);
            step(1);
        end
        chk("rand_underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
